// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-FF synchronised input, mid-bit sampling, glitch/framing/overrun detection.
// Byte appears HALF_BIT+9*BIT_TIME cycles after the start edge; a full holding register drops new bytes (o_overrun).
module uart_receiver #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  input  logic       i_data_ready,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int BIT_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT = BIT_TIME / 2;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_TIME - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  data_n;
  logic        valid_n, frame_err_n, overrun_n;
  logic        rx_meta, rx_sync;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shreg        <= shreg_n;
      o_data       <= data_n;
      o_data_valid <= valid_n;
      o_frame_err  <= frame_err_n;
      o_overrun    <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    data_n      = o_data;
    valid_n     = o_data_valid & ~i_data_ready;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_sync ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_sync, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (!rx_sync) begin
            frame_err_n = 1'b1;
            state_n     = WAIT_IDLE;
          end else begin
            // Back to IDLE at mid-stop so an immediately following start bit is caught.
            state_n = IDLE;
            if (!o_data_valid || i_data_ready) begin
              data_n  = shreg;
              valid_n = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at BIT_TIME=16: scenario tasks plus a randomized frame stream vs. an event-time model.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_rx;
  logic       i_data_ready;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_frame_err;
  logic       o_overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Events observed on the outputs, stamped with the cycle of the edge that produced them.
  int         ld_cyc[$];
  logic [7:0] ld_dat[$];
  int         fe_cyc[$];
  int         ov_cyc[$];
  logic       prev_vld = 1'b0;
  logic [7:0] prev_dat = 8'h00;

  uart_receiver #(.BAUD_RATE(10), .CLOCK_FREQ(160)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (i_rx),
    .i_data_ready (i_data_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_data_valid && (!prev_vld || o_data !== prev_dat)) begin
      ld_cyc.push_back(cyc);
      ld_dat.push_back(o_data);
    end
    if (o_frame_err) fe_cyc.push_back(cyc);
    if (o_overrun)   ov_cyc.push_back(cyc);
    prev_vld <= o_data_valid;
    prev_dat <= o_data;
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic line(input logic b, input int n);
    i_rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A frame whose line drops at cycle s has its stop sample at edge s+3+8+144 = s+155.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int start);
    start = cyc;
    line(1'b0, 16);
    for (int i = 0; i < 8; i++) line(d[i], 16);
    line(stop, 16);
  endtask

  task automatic clear_q();
    ld_cyc.delete();
    ld_dat.delete();
    fe_cyc.delete();
    ov_cyc.delete();
  endtask

  task automatic test_reset();
    total++; if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", o_data); end
    total++; if (o_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", o_data_valid); end
    total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %0b want 0", o_frame_err); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %0b want 0", o_overrun); end
    rst = 1'b0;
    line(1'b1, 20);
    total++; if (o_data_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %0b want 0", o_data_valid); end
  endtask

  task automatic test_basic();
    int s;
    clear_q();
    i_data_ready = 1'b0;
    send_frame(8'hA5, 1'b1, s);
    line(1'b1, 20);
    total++;
    if (ld_cyc.size() !== 1) begin
      bad++; $display("FAIL basic_count: got %0d loads want 1", ld_cyc.size());
    end else begin
      total++; if (ld_cyc[0] !== s + 155) begin bad++; $display("FAIL basic_time: got %0d want %0d", ld_cyc[0], s + 155); end
      total++; if (ld_dat[0] !== 8'hA5) begin bad++; $display("FAIL basic_data: got %0h want a5", ld_dat[0]); end
    end
    total++; if (o_data_valid !== 1'b1) begin bad++; $display("FAIL basic_hold: got %0b want 1", o_data_valid); end
    i_data_ready = 1'b1;
    @(posedge clk); #1;
    i_data_ready = 1'b0;
    total++; if (o_data_valid !== 1'b0) begin bad++; $display("FAIL basic_consume: got %0b want 0", o_data_valid); end
  endtask

  task automatic test_back_to_back();
    int s0, s1;
    clear_q();
    i_data_ready = 1'b1;
    send_frame(8'h00, 1'b1, s0);
    send_frame(8'hFF, 1'b1, s1);
    line(1'b1, 20);
    total++;
    if (ld_cyc.size() !== 2) begin
      bad++; $display("FAIL b2b_count: got %0d loads want 2", ld_cyc.size());
    end else begin
      total++; if (ld_cyc[0] !== s0 + 155) begin bad++; $display("FAIL b2b_time0: got %0d want %0d", ld_cyc[0], s0 + 155); end
      total++; if (ld_cyc[1] - ld_cyc[0] !== 160) begin bad++; $display("FAIL b2b_spacing: got %0d want 160", ld_cyc[1] - ld_cyc[0]); end
      total++; if (ld_dat[0] !== 8'h00) begin bad++; $display("FAIL b2b_data0: got %0h want 00", ld_dat[0]); end
      total++; if (ld_dat[1] !== 8'hFF) begin bad++; $display("FAIL b2b_data1: got %0h want ff", ld_dat[1]); end
    end
    total++; if (fe_cyc.size() + ov_cyc.size() !== 0) begin bad++; $display("FAIL b2b_pulses: got %0d want 0", fe_cyc.size() + ov_cyc.size()); end
  endtask

  task automatic test_glitch();
    clear_q();
    line(1'b0, 5);
    line(1'b1, 40);
    total++; if (ld_cyc.size() !== 0) begin bad++; $display("FAIL glitch_loads: got %0d want 0", ld_cyc.size()); end
    total++; if (fe_cyc.size() + ov_cyc.size() !== 0) begin bad++; $display("FAIL glitch_pulses: got %0d want 0", fe_cyc.size() + ov_cyc.size()); end
    total++; if (o_data_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid: got %0b want 0", o_data_valid); end
  endtask

  task automatic test_frame_err();
    int s, s2;
    clear_q();
    i_data_ready = 1'b1;
    send_frame(8'h3C, 1'b0, s);
    line(1'b0, 50);
    line(1'b1, 20);
    total++;
    if (fe_cyc.size() !== 1) begin
      bad++; $display("FAIL ferr_count: got %0d want 1", fe_cyc.size());
    end else begin
      total++; if (fe_cyc[0] !== s + 155) begin bad++; $display("FAIL ferr_time: got %0d want %0d", fe_cyc[0], s + 155); end
    end
    total++; if (ld_cyc.size() !== 0) begin bad++; $display("FAIL ferr_loads: got %0d want 0", ld_cyc.size()); end
    clear_q();
    send_frame(8'h3C, 1'b1, s2);
    line(1'b1, 20);
    total++;
    if (ld_cyc.size() !== 1) begin
      bad++; $display("FAIL ferr_next_count: got %0d want 1", ld_cyc.size());
    end else begin
      total++; if (ld_cyc[0] !== s2 + 155) begin bad++; $display("FAIL ferr_next_time: got %0d want %0d", ld_cyc[0], s2 + 155); end
      total++; if (ld_dat[0] !== 8'h3C) begin bad++; $display("FAIL ferr_next_data: got %0h want 3c", ld_dat[0]); end
    end
    total++; if (fe_cyc.size() !== 0) begin bad++; $display("FAIL ferr_next_pulse: got %0d want 0", fe_cyc.size()); end
  endtask

  task automatic test_overrun();
    int s1, s2, s3;
    clear_q();
    i_data_ready = 1'b0;
    send_frame(8'h11, 1'b1, s1);
    send_frame(8'h22, 1'b1, s2);
    line(1'b1, 10);
    total++;
    if (ov_cyc.size() !== 1) begin
      bad++; $display("FAIL ovr_count: got %0d want 1", ov_cyc.size());
    end else begin
      total++; if (ov_cyc[0] !== s2 + 155) begin bad++; $display("FAIL ovr_time: got %0d want %0d", ov_cyc[0], s2 + 155); end
    end
    total++; if (o_data !== 8'h11) begin bad++; $display("FAIL ovr_keep: got %0h want 11", o_data); end
    total++; if (ld_cyc.size() !== 1) begin bad++; $display("FAIL ovr_loads: got %0d want 1", ld_cyc.size()); end
    clear_q();
    fork
      send_frame(8'h33, 1'b1, s3);
      begin
        repeat (154) @(posedge clk);
        #1;
        i_data_ready = 1'b1;
        @(posedge clk); #1;
        i_data_ready = 1'b0;
      end
    join
    line(1'b1, 10);
    total++;
    if (ld_cyc.size() !== 1) begin
      bad++; $display("FAIL swap_count: got %0d want 1", ld_cyc.size());
    end else begin
      total++; if (ld_cyc[0] !== s3 + 155) begin bad++; $display("FAIL swap_time: got %0d want %0d", ld_cyc[0], s3 + 155); end
    end
    total++; if (o_data !== 8'h33) begin bad++; $display("FAIL swap_data: got %0h want 33", o_data); end
    total++; if (o_data_valid !== 1'b1) begin bad++; $display("FAIL swap_valid: got %0b want 1", o_data_valid); end
    total++; if (ov_cyc.size() !== 0) begin bad++; $display("FAIL swap_overrun: got %0d want 0", ov_cyc.size()); end
    i_data_ready = 1'b1;
    @(posedge clk); #1;
    i_data_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    int s;
    d = 8'h5A;
    clear_q();
    i_data_ready = 1'b0;
    line(1'b0, 16);
    for (int i = 0; i < 3; i++) line(d[i], 16);
    line(d[3], 8);
    rst = 1'b1;
    #1;
    total++; if (o_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %0h want 0", o_data); end
    total++; if (o_data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", o_data_valid); end
    line(1'b1, 3);
    rst = 1'b0;
    line(1'b1, 30);
    total++; if (fe_cyc.size() + ov_cyc.size() + ld_cyc.size() !== 0) begin bad++; $display("FAIL rst_events: got %0d want 0", fe_cyc.size() + ov_cyc.size() + ld_cyc.size()); end
    send_frame(d, 1'b1, s);
    line(1'b1, 20);
    total++;
    if (ld_cyc.size() !== 1) begin
      bad++; $display("FAIL rst_next_count: got %0d want 1", ld_cyc.size());
    end else begin
      total++; if (ld_cyc[0] !== s + 155) begin bad++; $display("FAIL rst_next_time: got %0d want %0d", ld_cyc[0], s + 155); end
      total++; if (ld_dat[0] !== 8'h5A) begin bad++; $display("FAIL rst_next_data: got %0h want 5a", ld_dat[0]); end
    end
    i_data_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int         e_ld_cyc[$];
    logic [7:0] e_ld_dat[$];
    int         e_fe_cyc[$];
    int         s, gap;
    logic [7:0] d;
    logic       bad_stop;
    clear_q();
    i_data_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      d        = 8'($urandom_range(0, 255));
      bad_stop = (n == 2) || ($urandom_range(0, 4) == 0);
      send_frame(d, !bad_stop, s);
      if (bad_stop) e_fe_cyc.push_back(s + 155);
      else begin
        e_ld_cyc.push_back(s + 155);
        e_ld_dat.push_back(d);
      end
      gap = int'($urandom_range(0, 20)) + (bad_stop ? 4 : 0);
      if (gap > 0) line(1'b1, gap);
    end
    line(1'b1, 20);
    total++;
    if (ld_cyc.size() !== e_ld_cyc.size()) begin
      bad++; $display("FAIL rand_loads: got %0d want %0d", ld_cyc.size(), e_ld_cyc.size());
    end else begin
      foreach (e_ld_cyc[k]) begin
        total++; if (ld_cyc[k] !== e_ld_cyc[k]) begin bad++; $display("FAIL rand_time[%0d]: got %0d want %0d", k, ld_cyc[k], e_ld_cyc[k]); end
        total++; if (ld_dat[k] !== e_ld_dat[k]) begin bad++; $display("FAIL rand_data[%0d]: got %0h want %0h", k, ld_dat[k], e_ld_dat[k]); end
      end
    end
    total++;
    if (fe_cyc.size() !== e_fe_cyc.size()) begin
      bad++; $display("FAIL rand_ferr: got %0d want %0d", fe_cyc.size(), e_fe_cyc.size());
    end else begin
      foreach (e_fe_cyc[k]) begin
        total++; if (fe_cyc[k] !== e_fe_cyc[k]) begin bad++; $display("FAIL rand_ferr_time[%0d]: got %0d want %0d", k, fe_cyc[k], e_fe_cyc[k]); end
      end
    end
    total++; if (ov_cyc.size() !== 0) begin bad++; $display("FAIL rand_overrun: got %0d want 0", ov_cyc.size()); end
  endtask

  initial begin
    rst          = 1'b1;
    i_rx         = 1'b1;
    i_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive block for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the receive-side counterpart to the design's UART transmitter, sits on the same external serial pin pair, and shares the BAUD_RATE/CLOCK_FREQ parameterisation. Received bytes are presented on a one-entry valid/ready output register. Glitch rejection, framing-error reporting and overrun reporting are built in.

## Interface
- BAUD_RATE, 9600: line rate in bits per second.
- CLOCK_FREQ, 50000000: clk frequency in Hz. BIT_TIME = CLOCK_FREQ / BAUD_RATE (integer division). HALF_BIT = BIT_TIME / 2. Legal range: 4 <= BIT_TIME <= 65535.
- clk  input  1  single clock for all logic.
- rst  input  1  reset; asynchronous, active-high.
- i_rx  input  1  serial line, asynchronous to clk, idle high.
- i_data_ready  input  1  consumer accepts o_data in any cycle where o_data_valid=1.
- o_data  output  8  received byte; stable while o_data_valid=1.
- o_data_valid  output  1  o_data holds an unconsumed byte.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: a good byte was dropped because the holding register was full.

## Operation
- Synchronizer: i_rx passes through a 2-FF synchronizer (both FFs reset to 1) to produce rx_sync. No other logic reads i_rx directly.
- Internal state:
  - 16-bit clock counter.
  - 3-bit bit index.
  - 8-bit shift register, filled LSB first: the sampled bit enters at bit 7 and the register shifts right.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: if rx_sync=0, go to START with counter=0.
- START: count to HALF_BIT-1.
  - rx_sync=0 at that point: go to DATA with counter=0 and index=0.
  - rx_sync=1 at that point: false start (glitch). Return to IDLE; no outputs change.
- DATA: count to BIT_TIME-1, then sample rx_sync into the shift register and reset the counter.
  - After the 8th sample (index=7), go to STOP.
- STOP: at count BIT_TIME-1, sample rx_sync.
  - Sample 1, holding register free (o_data_valid=0, or i_data_ready=1 in the same cycle): load o_data from the shift register and set o_data_valid=1. Go to IDLE.
  - Sample 1, holding register full (o_data_valid=1 and i_data_ready=0): drop the new byte, keep the old o_data, pulse o_overrun. Go to IDLE.
  - Sample 0: pulse o_frame_err and discard the byte. Go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_sync=1, then go to IDLE. This prevents a break or line-low condition from being read as back-to-back start bits.
- Output handshake: o_data_valid clears on the edge where o_data_valid=1 and i_data_ready=1, unless a new byte loads on that same edge. In that case o_data takes the new byte and o_data_valid stays 1.
- i_data_ready has no effect while o_data_valid=0.

## Timing
- Reset values:
  - o_data=0, o_data_valid=0, o_frame_err=0, o_overrun=0.
  - Both synchronizer FFs = 1.
  - FSM = IDLE, counter = 0, index = 0, shift register = 0.
- Reset asserted mid-frame aborts the frame. The partial byte is discarded and no pulse is emitted.
- Define E0 as the edge at which IDLE sees rx_sync=0. This is the 3rd rising edge at which i_rx is sampled low.
  - Start check: edge E0+HALF_BIT.
  - Data bit k (k=0..7) sampled at edge E0+HALF_BIT+(k+1)*BIT_TIME.
  - Stop sampled at edge E0+HALF_BIT+9*BIT_TIME. o_data, o_data_valid, o_frame_err and o_overrun update on that same edge.
- o_frame_err and o_overrun are high for exactly one cycle per event.
- Return to IDLE after the stop sample happens at mid-stop-bit. A start bit that immediately follows is therefore detected with no lost frame.
- Sustained throughput: one byte per 10*BIT_TIME cycles, provided the consumer drains within 10*BIT_TIME cycles.

## Test plan
All tests use CLOCK_FREQ=160, BAUD_RATE=10, giving BIT_TIME=16 and HALF_BIT=8.
- Basic byte: send frame 0xA5 with i_data_ready=0 → o_data_valid rises at E0+152 with o_data=0xA5. Hold i_data_ready=1 for one cycle → o_data_valid clears on the next edge.
- Back-to-back frames: send 0x00 then 0xFF with no idle gap, i_data_ready tied 1 → two valid pulses exactly 160 cycles apart, data 0x00 then 0xFF, no error pulses.
- Glitch: drive i_rx low for 5 cycles, then high → FSM returns to IDLE, o_data_valid stays 0, no error pulses.
- Framing error: send frame 0x3C with the stop bit low, then hold i_rx low for 50 cycles, then high → one o_frame_err pulse, no o_data_valid, no second frame detected until i_rx returns high. A following 0x3C frame is received correctly.
- Overrun: send 0x11 then 0x22 with i_data_ready=0 → one o_overrun pulse at the 0x22 stop sample, o_data remains 0x11. For a third frame 0x33, assert i_data_ready exactly on its stop-sample edge → o_data=0x33, o_data_valid stays 1, no o_overrun.
- Mid-frame reset: pulse rst during data bit 3 of frame 0x5A, then send 0x5A again → all outputs go to reset values with no pulses, and the second 0x5A is received correctly.
